alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_req_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each accepted command is run on the ALU, its result is captured and returned with the requester id.
module alu_req_arbiter #(
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_cout,
  output logic              rsp_err,
  output logic              alu_as,
  output logic              alu_sub,
  output logic              alu_shift,
  output logic              alu_shift_left,
  output logic              alu_and,
  output logic              alu_or,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  output logic              busy
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_next;
  logic [2:0]  op;
  logic [3:0]  cnt;
  logic        last;
  logic        grant_id;
  logic        accept;
  logic        sel_illegal;
  logic [2:0]  sel_op;
  logic        last_exec;

  // last == 1 after reset so that req0 wins the first contended cycle
  assign grant_id    = (req0_valid && req1_valid) ? ~last : req1_valid;
  assign accept      = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready  = (state == IDLE) && req1_valid && grant_id;
  assign sel_op      = grant_id ? req1_op : req0_op;
  assign sel_illegal = (sel_op[2:1] == 2'b11);
  assign last_exec   = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    rsp_valid      = 1'b0;
    alu_as         = 1'b0;
    alu_sub        = 1'b0;
    alu_shift      = 1'b0;
    alu_shift_left = 1'b0;
    alu_and        = 1'b0;
    alu_or         = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = sel_illegal ? RESP : EXEC;
        end
      end
      EXEC: begin
        case (op)
          OP_ADD: alu_as = 1'b1;
          OP_SUB: begin alu_as = 1'b1; alu_sub = 1'b1; end
          OP_SHR: alu_shift = 1'b1;
          OP_SHL: begin alu_shift = 1'b1; alu_shift_left = 1'b1; end
          OP_AND: alu_and = 1'b1;
          OP_OR:  alu_or = 1'b1;
          default: ;
        endcase
        if (last_exec) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op       <= 3'd0;
      cnt      <= 4'd0;
      last     <= 1'b1;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_cout <= 1'b0;
      rsp_err  <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
    end else if (accept) begin
      op     <= sel_op;
      cnt    <= 4'd0;
      last   <= grant_id;
      rsp_id <= grant_id;
      alu_a  <= grant_id ? req1_a : req0_a;
      alu_b  <= grant_id ? req1_b : req0_b;
      if (sel_illegal) begin
        rsp_data <= '0;
        rsp_cout <= 1'b0;
        rsp_err  <= 1'b1;
      end
    end else if (state == EXEC) begin
      cnt <= cnt + 4'd1;
      if (last_exec) begin
        rsp_data <= alu_result;
        // only the adder produces a meaningful carry
        rsp_cout <= alu_cout && (op == OP_ADD || op == OP_SUB);
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: transaction-level model checked every cycle, plus directed literal checks.
// A second instance with a longer settle time is used for the reset-during-execute case.
module tb_alu_req_arbiter;

  localparam int S = 1;

  logic        clk;
  logic        rst_n, rst4_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        force_cout;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_err, busy;
  logic [31:0] rsp_data, alu_a, alu_b, alu_result;
  logic        alu_as, alu_sub, alu_shift, alu_shift_left, alu_and, alu_or, alu_cout;

  logic        req0_ready4, req1_ready4, rsp_valid4, rsp_id4, rsp_cout4, rsp_err4, busy4;
  logic [31:0] rsp_data4, alu_a4, alu_b4, alu_result4;
  logic        alu_as4, alu_sub4, alu_shift4, alu_shift_left4, alu_and4, alu_or4, alu_cout4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference ALU: add/sub with carry, shift by one (carry = bit shifted out), and, or
  function automatic logic [32:0] alu_fn(input logic f_as, f_sub, f_sh, f_shl, f_and, f_or,
                                         input logic [31:0] a, b);
    if (f_as)       return f_sub ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
    else if (f_sh)  return f_shl ? {a[31], a << 1} : {a[0], a >> 1};
    else if (f_and) return {1'b0, a & b};
    else if (f_or)  return {1'b0, a | b};
    return 33'd0;
  endfunction

  assign {alu_cout, alu_result} = alu_fn(alu_as, alu_sub, alu_shift, alu_shift_left, alu_and,
                                         alu_or, alu_a, alu_b) | {force_cout, 32'd0};
  assign {alu_cout4, alu_result4} = alu_fn(alu_as4, alu_sub4, alu_shift4, alu_shift_left4,
                                           alu_and4, alu_or4, alu_a4, alu_b4);

  alu_req_arbiter #(.DATA_W(32), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .alu_as(alu_as), .alu_sub(alu_sub), .alu_shift(alu_shift), .alu_shift_left(alu_shift_left),
    .alu_and(alu_and), .alu_or(alu_or), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_cout(alu_cout), .busy(busy)
  );

  alu_req_arbiter #(.DATA_W(32), .SETTLE_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst4_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready4), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready4), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4), .rsp_data(rsp_data4),
    .rsp_cout(rsp_cout4), .rsp_err(rsp_err4),
    .alu_as(alu_as4), .alu_sub(alu_sub4), .alu_shift(alu_shift4), .alu_shift_left(alu_shift_left4),
    .alu_and(alu_and4), .alu_or(alu_or4), .alu_a(alu_a4), .alu_b(alu_b4),
    .alu_result(alu_result4), .alu_cout(alu_cout4), .busy(busy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          cyc = 0;
  bit          m_active = 0;
  bit          m_last = 1;
  int          m_done = 0;
  logic [2:0]  m_op = 0;
  logic [31:0] m_a = 0, m_b = 0;
  logic        m_rid = 0, m_rcout = 0, m_rerr = 0;
  logic [31:0] m_rdata = 0;
  logic        e_valid, e_exec, e_g;
  logic [5:0]  e_ctrl;
  logic [32:0] e_sum;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ctrl", {alu_as, alu_sub, alu_shift, alu_shift_left, alu_and, alu_or}, 0);
      chk("rst_alu_ab", {alu_a, alu_b}, 0);
      chk("rst_rsp", {rsp_id, rsp_data, rsp_cout, rsp_err}, 0);
      m_active = 0;
      m_last   = 1;
      m_a      = 0;
      m_b      = 0;
    end else begin
      e_valid = m_active && (cyc >= m_done);
      e_exec  = m_active && (cyc < m_done);
      e_ctrl  = 6'b000000;
      if (e_exec) begin
        case (m_op)
          3'd0: e_ctrl = 6'b100000;
          3'd1: e_ctrl = 6'b110000;
          3'd2: e_ctrl = 6'b001000;
          3'd3: e_ctrl = 6'b001100;
          3'd4: e_ctrl = 6'b000010;
          3'd5: e_ctrl = 6'b000001;
          default: e_ctrl = 6'b000000;
        endcase
      end
      e_g = (req0_valid && req1_valid) ? !m_last : req1_valid;
      chk("busy", busy, m_active);
      chk("rsp_valid", rsp_valid, e_valid);
      chk("req0_ready", req0_ready, !m_active && req0_valid && !e_g);
      chk("req1_ready", req1_ready, !m_active && req1_valid && e_g);
      chk("alu_ctrl", {alu_as, alu_sub, alu_shift, alu_shift_left, alu_and, alu_or}, e_ctrl);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      if (e_valid) begin
        chk("rsp_id", rsp_id, m_rid);
        chk("rsp_data", rsp_data, m_rdata);
        chk("rsp_cout", rsp_cout, m_rcout);
        chk("rsp_err", rsp_err, m_rerr);
      end
      if (e_valid && rsp_ready) begin
        $display("rsp  id=%0d op=%0d a=%h b=%h data=%h cout=%0d err=%0d",
                 rsp_id, m_op, m_a, m_b, rsp_data, rsp_cout, rsp_err);
        m_active = 0;
      end else if (!m_active && (req0_valid || req1_valid)) begin
        m_active = 1;
        m_last   = e_g;
        m_rid    = e_g;
        m_op     = e_g ? req1_op : req0_op;
        m_a      = e_g ? req1_a : req0_a;
        m_b      = e_g ? req1_b : req0_b;
        m_rerr   = 0;
        m_rcout  = 0;
        case (m_op)
          3'd0: begin e_sum = {1'b0, m_a} + {1'b0, m_b}; m_rdata = e_sum[31:0]; m_rcout = e_sum[32]; end
          3'd1: begin m_rdata = m_a - m_b; m_rcout = (m_a >= m_b); end
          3'd2: m_rdata = m_a >> 1;
          3'd3: m_rdata = m_a << 1;
          3'd4: m_rdata = m_a & m_b;
          3'd5: m_rdata = m_a | m_b;
          default: begin m_rdata = 0; m_rerr = 1; end
        endcase
        m_done = cyc + 1 + ((m_op >= 3'd6) ? 0 : S);
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic run_one(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
    bit acc;
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      acc = id ? req1_ready : req0_ready;
      @(posedge clk); #1;
      lat++;
      if (acc) begin
        if (id) req1_valid = 0; else req0_valid = 0;
      end
      if (rsp_valid) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL run_one_timeout: got no response, expected one within 30 cycles");
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int          lat;
  int          gq[$];
  logic [31:0] rq[$];
  bit          exp_g[4]  = '{0, 1, 0, 1};
  logic [31:0] exp_r[4]  = '{32'd50, 32'hAAAAAAAA, 32'd50, 32'hAAAAAAAA};

  initial begin
    rst_n = 1; rst4_n = 1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1; force_cout = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    #1 rst_n = 0; rst4_n = 0;
    #1;
    chk("lit_reset_busy", busy, 0);
    chk("lit_reset_alu_a", alu_a, 0);
    idle_cycles(2);
    rst_n = 1;
    idle_cycles(1);

    // ADD, two cycles from valid to response
    run_one(0, 3'd0, 32'd22, 32'd33, lat);
    chk("lit_add_latency", lat, 2);
    chk("lit_add_data", rsp_data, 32'd55);
    chk("lit_add_id", rsp_id, 0);
    chk("lit_add_cout_err", {rsp_cout, rsp_err}, 0);
    idle_cycles(2);

    // Backpressure with a competing request pending
    rsp_ready = 0;
    run_one(0, 3'd5, 32'h000000F0, 32'h0000000F, lat);
    req1_valid = 1; req1_op = 3'd0; req1_a = 32'd7; req1_b = 32'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lit_bp_valid", rsp_valid, 1);
      chk("lit_bp_data", rsp_data, 32'h000000FF);
      chk("lit_bp_req1_ready", req1_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    for (int i = 0; i < 10 && req1_valid; i++) begin
      @(negedge clk);
      if (req1_ready) begin @(posedge clk); #1; req1_valid = 0; end
      else begin @(posedge clk); #1; end
    end
    idle_cycles(4);

    // Illegal opcode goes straight to response
    run_one(1, 3'd7, 32'h12345678, 32'h9ABCDEF0, lat);
    chk("lit_ill_latency", lat, 1);
    chk("lit_ill_data", rsp_data, 0);
    chk("lit_ill_err", rsp_err, 1);
    chk("lit_ill_ctrl", {alu_as, alu_sub, alu_shift, alu_shift_left, alu_and, alu_or}, 0);
    idle_cycles(2);

    // Shift left with carry forced high: carry must be dropped
    force_cout = 1;
    run_one(0, 3'd3, 32'hFFFFFFFF, 32'd0, lat);
    chk("lit_shl_data", rsp_data, 32'hFFFFFFFE);
    chk("lit_shl_cout", rsp_cout, 0);
    idle_cycles(1);
    force_cout = 0;
    idle_cycles(1);

    // Contention from a fresh reset
    rst_n = 0;
    idle_cycles(1);
    rst_n = 1;
    req0_op = 3'd1; req0_a = 32'd100; req0_b = 32'd50;
    req1_op = 3'd4; req1_a = 32'hFFFFFFFF; req1_b = 32'hAAAAAAAA;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req0_ready) gq.push_back(0);
      if (req1_ready) gq.push_back(1);
      if (rsp_valid) rq.push_back(rsp_data);
      if (rq.size() == 4) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    chk("lit_cont_grants", gq.size(), 4);
    chk("lit_cont_resps", rq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++) chk($sformatf("lit_cont_grant%0d", k), gq[k], exp_g[k]);
    for (int k = 0; k < 4 && k < rq.size(); k++) chk($sformatf("lit_cont_resp%0d", k), rq[k], exp_r[k]);
    idle_cycles(2);

    // Reset in the middle of a four-cycle execute
    rst_n = 0; rst4_n = 0;
    idle_cycles(1);
    rst_n = 1; rst4_n = 1;
    req0_valid = 1; req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd2;
    @(negedge clk);
    chk("lit_r4_ready0", req0_ready4, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    @(posedge clk); #1;
    chk("lit_r4_busy_before", busy4, 1);
    rst_n = 0; rst4_n = 0;
    #1;
    chk("lit_r4_busy", busy4, 0);
    chk("lit_r4_rsp_valid", rsp_valid4, 0);
    chk("lit_r4_alu_a", alu_a4, 0);
    chk("lit_r4_ctrl", {alu_as4, alu_sub4, alu_shift4, alu_shift_left4, alu_and4, alu_or4}, 0);
    @(posedge clk); #1;
    rst_n = 1; rst4_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lit_r4_no_rsp", rsp_valid4, 0);
      @(posedge clk); #1;
    end
    req0_valid = 1; req1_valid = 1;
    req1_op = 3'd5; req1_a = 32'd3; req1_b = 32'd4;
    @(negedge clk);
    chk("lit_r4_grant0", req0_ready4, 1);
    chk("lit_r4_grant1", req1_ready4, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    idle_cycles(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
